dac_amplitude_ramp: RTL and testbench

Downstream stage of the signal generator; consumes its 16-bit sample stream and drives the DAC-facing AXI-Stream.
Applies a static amplitude gain, a soft-start/soft-stop envelope driven by a ramp state machine, and a DC offset, then saturates to the 14-bit DAC range.
Prevents output steps when a waveform is enabled or disabled.

---
 rtl/dac_ramp_pkg.sv | 21 ++
 rtl/ramp_envelope.sv | 80 ++++++++
 rtl/dac_amplitude_ramp.sv | 132 +++++++++++++
 tb/tb_dac_amplitude_ramp.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_ramp_pkg.sv
// Shared types and constants for the DAC amplitude/envelope stage.
package dac_ramp_pkg;

  typedef enum logic [1:0] {
    RAMP_IDLE = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_HOLD = 2'd2,
    RAMP_DOWN = 2'd3
  } ramp_state_e;

  localparam int DAC_MAX = 8191;
  localparam int DAC_MIN = -8191;

  localparam int CFG_AMP_LSB  = 0;
  localparam int CFG_OFS_LSB  = 16;
  localparam int CFG_STEP_LSB = 32;

  localparam int ENV_W = 16;
  localparam logic [ENV_W-1:0] ENV_MAX = '1;

endpackage

// File: rtl/ramp_envelope.sv
// Soft-start/soft-stop state machine with a saturating unsigned envelope accumulator.
module ramp_envelope
  import dac_ramp_pkg::*;
#(
  parameter int ENV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic [ENV_WIDTH-1:0] step,
  input  logic                 ramp_start,
  input  logic                 ramp_stop,
  output logic [ENV_WIDTH-1:0] env,
  output ramp_state_e          state,
  output logic                 ramp_done
);

  localparam logic [ENV_WIDTH-1:0] ENV_TOP = {ENV_WIDTH{1'b1}};

  ramp_state_e          state_n;
  logic [ENV_WIDTH-1:0] env_n;
  logic [ENV_WIDTH-1:0] env_up;
  logic [ENV_WIDTH-1:0] env_dn;
  logic [ENV_WIDTH:0]   env_sum;
  logic                 done_n;

  // A zero step means "jump": straight to full scale going up, straight to zero going down.
  assign env_sum = {1'b0, env} + {1'b0, step};
  assign env_up  = (step == '0 || env_sum[ENV_WIDTH]) ? ENV_TOP : env_sum[ENV_WIDTH-1:0];
  assign env_dn  = (step == '0 || step >= env) ? '0 : env - step;

  always_comb begin
    state_n = state;
    env_n   = env;
    done_n  = 1'b0;
    case (state)
      RAMP_IDLE: begin
        env_n = '0;
        if (ramp_start && !ramp_stop) state_n = RAMP_UP;
      end
      RAMP_UP: begin
        if (ramp_stop) begin
          state_n = RAMP_DOWN;
        end else begin
          env_n = env_up;
          if (env_up == ENV_TOP) state_n = RAMP_HOLD;
        end
      end
      RAMP_HOLD: begin
        env_n = ENV_TOP;
        if (ramp_stop) state_n = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        // Re-start resumes from the current level so the output never steps.
        if (ramp_start && !ramp_stop) begin
          state_n = RAMP_UP;
        end else begin
          env_n = env_dn;
          if (env_dn == '0) begin
            state_n = RAMP_IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = RAMP_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state     <= RAMP_IDLE;
      env       <= '0;
      ramp_done <= 1'b0;
    end else begin
      state     <= state_n;
      env       <= env_n;
      ramp_done <= done_n;
    end
  end

endmodule

// File: rtl/dac_amplitude_ramp.sv
// Gain, soft-start/stop envelope and DC offset on the sample stream, saturated to the DAC range.
// Define DAC_RAMP_ROUND_EN for round-half-up in the gain and envelope stages (default truncates).
module dac_amplitude_ramp
  import dac_ramp_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter int DAC_WIDTH        = 14,
  parameter int ENV_WIDTH        = $bits(ENV_MAX),
  parameter int CFG_DATA_WIDTH   = 64
) (
  input  logic                               clk,
  input  logic                               areset,
  input  logic signed [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                               s_axis_tvalid,
  input  logic [CFG_DATA_WIDTH-1:0]          cfg_data,
  input  logic                               ramp_start,
  input  logic                               ramp_stop,
  output logic signed [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                               m_axis_tvalid,
  output logic [1:0]                         ramp_state,
  output logic                               ramp_done
);

  localparam int P1_W    = AXIS_TDATA_WIDTH + 1;
  localparam int PROD1_W = 2 * AXIS_TDATA_WIDTH;
  localparam int P2_W    = P1_W;
  localparam int PROD2_W = P1_W + ENV_WIDTH + 1;
  localparam int S3_W    = P2_W + 1;

  localparam logic signed [S3_W-1:0] CLAMP_HI = S3_W'(DAC_MAX);
  localparam logic signed [S3_W-1:0] CLAMP_LO = S3_W'(DAC_MIN);

`ifdef DAC_RAMP_ROUND_EN
  localparam logic signed [PROD1_W-1:0] HALF1 = PROD1_W'(2 ** (AXIS_TDATA_WIDTH - 2));
  localparam logic signed [PROD2_W-1:0] HALF2 = PROD2_W'(2 ** (ENV_WIDTH - 1));
`endif

  function automatic logic signed [P1_W-1:0] scale_gain(input logic signed [PROD1_W-1:0] prod);
`ifdef DAC_RAMP_ROUND_EN
    return P1_W'((prod + HALF1) >>> (AXIS_TDATA_WIDTH - 1));
`else
    return P1_W'(prod >>> (AXIS_TDATA_WIDTH - 1));
`endif
  endfunction

  function automatic logic signed [P2_W-1:0] scale_env(input logic signed [PROD2_W-1:0] prod);
`ifdef DAC_RAMP_ROUND_EN
    return P2_W'((prod + HALF2) >>> ENV_WIDTH);
`else
    return P2_W'(prod >>> ENV_WIDTH);
`endif
  endfunction

  function automatic logic signed [DAC_WIDTH-1:0] dac_clamp(input logic signed [S3_W-1:0] v);
    if (v > CLAMP_HI) return DAC_WIDTH'(CLAMP_HI);
    if (v < CLAMP_LO) return DAC_WIDTH'(CLAMP_LO);
    return DAC_WIDTH'(v);
  endfunction

  logic signed [AXIS_TDATA_WIDTH-1:0] amp_q;
  logic signed [AXIS_TDATA_WIDTH-1:0] ofs_q;
  logic [ENV_WIDTH-1:0]               step_q;
  logic                               unused_cfg;

  logic [ENV_WIDTH-1:0]      env;
  logic signed [ENV_WIDTH:0] env_s;
  ramp_state_e               env_state;

  logic signed [PROD1_W-1:0] prod_p0;
  logic signed [P1_W-1:0]    p1_p1;
  logic                      vld_p1;
  logic signed [PROD2_W-1:0] prod_p1;
  logic signed [P2_W-1:0]    p2_p2;
  logic                      vld_p2;
  logic signed [S3_W-1:0]    sum_p2;

  assign unused_cfg = ^cfg_data[CFG_DATA_WIDTH-1:CFG_STEP_LSB+ENV_WIDTH];

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      amp_q  <= '0;
      ofs_q  <= '0;
      step_q <= '0;
    end else begin
      amp_q  <= cfg_data[CFG_AMP_LSB +: AXIS_TDATA_WIDTH];
      ofs_q  <= cfg_data[CFG_OFS_LSB +: AXIS_TDATA_WIDTH];
      step_q <= cfg_data[CFG_STEP_LSB +: ENV_WIDTH];
    end
  end

  ramp_envelope #(
    .ENV_WIDTH(ENV_WIDTH)
  ) u_env (
    .clk       (clk),
    .areset    (areset),
    .step      (step_q),
    .ramp_start(ramp_start),
    .ramp_stop (ramp_stop),
    .env       (env),
    .state     (env_state),
    .ramp_done (ramp_done)
  );

  assign ramp_state = env_state;
  assign env_s      = {1'b0, env};

  // Stage 1: static gain; 17-bit result so full-scale negative squared fits.
  assign prod_p0 = PROD1_W'(s_axis_tdata) * PROD1_W'(amp_q);
  // Stage 2: envelope scaling by unsigned Q0.ENV_WIDTH.
  assign prod_p1 = PROD2_W'(p1_p1) * PROD2_W'(env_s);
  // Stage 3: offset add, saturate, sign-extend to the stream width.
  assign sum_p2  = S3_W'(p2_p2) + S3_W'(ofs_q);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      p1_p1         <= '0;
      vld_p1        <= 1'b0;
      p2_p2         <= '0;
      vld_p2        <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
    end else begin
      p1_p1         <= scale_gain(prod_p0);
      vld_p1        <= s_axis_tvalid;
      p2_p2         <= scale_env(prod_p1);
      vld_p2        <= vld_p1;
      m_axis_tdata  <= AXIS_TDATA_WIDTH'(dac_clamp(sum_p2));
      m_axis_tvalid <= vld_p2;
    end
  end

endmodule

// File: tb/tb_dac_amplitude_ramp.sv
// Directed plus randomized bench for dac_amplitude_ramp against an arithmetic reference model.
module tb_dac_amplitude_ramp;

  logic               clk = 1'b0;
  logic               areset = 1'b1;
  logic signed [15:0] s_tdata = '0;
  logic               s_tvalid = 1'b0;
  logic [63:0]        cfg = '0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic signed [15:0] m_tdata;
  logic               m_tvalid;
  logic [1:0]         r_state;
  logic               r_done;

  always #4 clk = ~clk;

  dac_amplitude_ramp dut (
    .clk          (clk),
    .areset       (areset),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .cfg_data     (cfg),
    .ramp_start   (start),
    .ramp_stop    (stop),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .ramp_state   (r_state),
    .ramp_done    (r_done)
  );

  localparam int EMAX = 65535;
`ifdef DAC_RAMP_ROUND_EN
  localparam int GAIN_EXP = 4000;
`else
  localparam int GAIN_EXP = 3999;
`endif

  int n_assert = 0;
  int n_fail = 0;

  // reference model state (values in effect before the next clock edge)
  int m_amp, m_ofs, m_step, m_env, m_st;
  bit m_done;
  int h_smp[4], h_amp[4], h_env[4], h_ofs[4];
  bit h_vld[4];
  int ec;
  int e_data;
  bit e_vld;

  function automatic longint fdiv(input longint a, input longint b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic int expect_out(input int smp, input int amp, input int env, input int ofs);
    longint p1, p2, s;
`ifdef DAC_RAMP_ROUND_EN
    p1 = fdiv(longint'(smp) * amp + 16384, 32768);
    p2 = fdiv(p1 * env + 32768, 65536);
`else
    p1 = fdiv(longint'(smp) * amp, 32768);
    p2 = fdiv(p1 * env, 65536);
`endif
    s = p2 + ofs;
    if (s > 8191) s = 8191;
    if (s < -8191) s = -8191;
    return int'(s);
  endfunction

  task automatic model_reset();
    m_amp = 0; m_ofs = 0; m_step = 0; m_env = 0; m_st = 0; m_done = 0;
    for (int i = 0; i < 4; i++) begin
      h_smp[i] = 0; h_amp[i] = 0; h_env[i] = 0; h_ofs[i] = 0; h_vld[i] = 0;
    end
    ec = 3;
    e_data = 0;
    e_vld = 0;
  endtask

  task automatic model_edge();
    int idx, nst, nenv;
    bit nd;
    ec++;
    idx = ec % 4;
    h_smp[idx] = s_tdata;
    h_vld[idx] = s_tvalid;
    h_amp[idx] = m_amp;
    h_env[idx] = m_env;
    h_ofs[idx] = m_ofs;
    e_vld  = h_vld[(ec - 2) % 4];
    e_data = expect_out(h_smp[(ec - 2) % 4], h_amp[(ec - 2) % 4], h_env[(ec - 1) % 4], h_ofs[idx]);
    nst = m_st; nenv = m_env; nd = 0;
    case (m_st)
      0: begin
        nenv = 0;
        if (start && !stop) nst = 1;
      end
      1: if (stop) nst = 3;
         else begin
           nenv = (m_step == 0) ? EMAX : ((m_env + m_step > EMAX) ? EMAX : m_env + m_step);
           if (nenv == EMAX) nst = 2;
         end
      2: begin
        nenv = EMAX;
        if (stop) nst = 3;
      end
      default: if (start && !stop) nst = 1;
         else begin
           nenv = (m_step == 0) ? 0 : ((m_env - m_step < 0) ? 0 : m_env - m_step);
           if (nenv == 0) begin nst = 0; nd = 1; end
         end
    endcase
    m_st = nst; m_env = nenv; m_done = nd;
    m_amp  = int'($signed(cfg[15:0]));
    m_ofs  = int'($signed(cfg[31:16]));
    m_step = int'(cfg[47:32]);
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("tvalid", m_tvalid, e_vld);
    if (e_vld) chk("tdata", m_tdata, e_data);
    chk("state", r_state, m_st);
    chk("done", r_done, m_done);
    chk("env", dut.u_env.env, m_env);
  endtask

  task automatic tick();
    @(posedge clk);
    if (areset) model_reset();
    else model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_cfg(input int amp, input int ofs, input int step);
    cfg = {16'h0, 16'(step), 16'(ofs), 16'(amp)};
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  int up_env[4];
  int up_st[4];
  int dn_env[4];
  bit vin[8];

  initial begin
    up_env[0] = 16384; up_env[1] = 32768; up_env[2] = 49152; up_env[3] = 65535;
    up_st[0] = 1; up_st[1] = 1; up_st[2] = 1; up_st[3] = 2;
    dn_env[0] = 49151; dn_env[1] = 32767; dn_env[2] = 16383; dn_env[3] = 0;
    vin[0] = 1; vin[1] = 0; vin[2] = 1; vin[3] = 1;
    vin[4] = 0; vin[5] = 0; vin[6] = 0; vin[7] = 0;
    model_reset();

    // reset, including an asynchronous reset in the middle of a ramp-up
    tick(); tick();
    areset = 1'b0;
    set_cfg(16384, 100, 16384);
    s_tdata = 16'sd8000; s_tvalid = 1'b1;
    tick();
    pulse_start();
    tick(); tick();
    chk("pre_rst_env", dut.u_env.env, 32768);
    areset = 1'b1;
    #1;
    model_reset();
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_state", r_state, 0);
    chk("rst_env", dut.u_env.env, 0);
    tick(); tick();
    areset = 1'b0;
    repeat (3) tick();
    chk("post_rst_env", dut.u_env.env, 0);

    // gain through a fully open envelope
    set_cfg(16384, 0, 0);
    tick();
    pulse_start();
    tick();
    chk("hold_state", r_state, 2);
    repeat (4) tick();
    chk("gain", m_tdata, GAIN_EXP);

    // saturation corners
    set_cfg(32767, 4000, 0); s_tdata = 16'sd8191;
    repeat (4) tick();
    chk("sat_pos", m_tdata, 8191);
    set_cfg(32767, -4000, 0); s_tdata = -16'sd8191;
    repeat (4) tick();
    chk("sat_neg", m_tdata, -8191);
    set_cfg(-32768, -4000, 0); s_tdata = -16'sd32768;
    repeat (4) tick();
    chk("sat_nowrap", m_tdata, 8191);

    // full ramp up and down with step 16384
    pulse_stop();
    tick();
    chk("jump_idle", r_state, 0);
    set_cfg(12000, 0, 16384);
    tick();
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("up_env", dut.u_env.env, up_env[i]);
      chk("up_state", r_state, up_st[i]);
    end
    pulse_stop();
    chk("down_state", r_state, 3);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("down_env", dut.u_env.env, dn_env[i]);
    end
    chk("down_idle", r_state, 0);
    chk("done_pulse", r_done, 1);
    tick();
    chk("done_clear", r_done, 0);

    // concurrent and ignored events
    pulse_start();
    repeat (4) tick();
    chk("hold_again", r_state, 2);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("stop_wins", r_state, 3);
    tick(); tick();
    chk("down_mid", dut.u_env.env, 32767);
    pulse_start();
    chk("restart_state", r_state, 1);
    tick();
    chk("restart_env", dut.u_env.env, 49151);
    pulse_stop();
    for (int i = 0; i < 10 && r_state != 2'd0; i++) tick();
    chk("back_idle", r_state, 0);
    pulse_stop();
    chk("idle_stop_state", r_state, 0);
    chk("idle_stop_done", r_done, 0);

    // valid pattern through the pipeline at full envelope
    set_cfg(20000, 50, 0);
    tick();
    pulse_start();
    tick();
    s_tdata = 16'sd1000;
    for (int k = 0; k < 8; k++) begin
      s_tvalid = vin[k];
      tick();
      if (k >= 2) chk("vld_pattern", m_tvalid, vin[k - 2]);
    end

    // randomized traffic, configuration and ramp commands
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) begin
        case ($urandom % 4)
          0: set_cfg(int'($urandom), int'($urandom_range(18000)) - 9000, 0);
          1: set_cfg(int'($urandom), int'($urandom_range(18000)) - 9000, 16384);
          2: set_cfg(int'($urandom), int'($urandom_range(18000)) - 9000, int'($urandom_range(4095, 1)));
          default: set_cfg(int'($urandom), int'($urandom_range(18000)) - 9000, 65535);
        endcase
      end
      start = ($urandom % 8 == 0);
      stop = ($urandom % 12 == 0);
      s_tdata = 16'($urandom);
      s_tvalid = ($urandom % 4 != 0);
      tick();
    end
    start = 1'b0; stop = 1'b0; s_tvalid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
